// File: rtl/hold_sched.sv
// rtl/hold_sched.sv - pipeline hold/flush scheduler with post-jump flush window and jtag halt drain.
// Optional rib stall timeout counter enabled by HOLD_TIMEOUT_EN.
module hold_sched #(
    parameter int FLUSH_CYCLES = 2,
    parameter int RIB_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_rib_i,
    input  logic        hold_flag_clint_i,
    input  logic        jtag_halt_req_i,
    output logic        jtag_halt_ack_o,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        rib_timeout_o
);

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_ID   = 3'b011;
    localparam logic [2:0] RELOAD    = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {S_RUN, S_FLUSH, S_DRAIN, S_HALTED, S_RESUME} state_t;

    state_t     state, state_nxt, jump_state;
    logic [2:0] flush_cnt, cnt_nxt;
    logic       ack_nxt;

    // A jump only opens a flush window when it lasts beyond the jump cycle itself.
    assign jump_state = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_RUN;
            flush_cnt       <= 3'd0;
            jtag_halt_ack_o <= 1'b0;
        end else begin
            state           <= state_nxt;
            flush_cnt       <= cnt_nxt;
            jtag_halt_ack_o <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = flush_cnt;
        ack_nxt   = jtag_halt_ack_o;
        case (state)
            S_RUN, S_RESUME: begin
                if (jump_flag_i) begin
                    cnt_nxt   = RELOAD;
                    state_nxt = jump_state;
                end else if (state == S_RUN && jtag_halt_req_i) begin
                    state_nxt = S_DRAIN;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                if (jump_flag_i) begin
                    cnt_nxt = RELOAD;
                end else if (flush_cnt <= 3'd1) begin
                    cnt_nxt   = 3'd0;
                    state_nxt = jtag_halt_req_i ? S_DRAIN : S_RUN;
                end else begin
                    cnt_nxt = flush_cnt - 3'd1;
                end
            end
            S_DRAIN: begin
                if (!jtag_halt_req_i) begin
                    cnt_nxt   = jump_flag_i ? RELOAD : 3'd0;
                    state_nxt = jump_flag_i ? jump_state : S_RUN;
                end else if (jump_flag_i) begin
                    cnt_nxt = RELOAD;
                end else if (!hold_flag_ex_i && !hold_flag_clint_i && flush_cnt == 3'd0) begin
                    state_nxt = S_HALTED;
                    ack_nxt   = 1'b1;
                end else if (flush_cnt != 3'd0) begin
                    cnt_nxt = flush_cnt - 3'd1;
                end
            end
            S_HALTED: begin
                if (!jtag_halt_req_i) begin
                    ack_nxt   = 1'b0;
                    state_nxt = S_RESUME;
                end
            end
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_comb begin
        hold_flag_o = HOLD_ID;
        if (rst) begin
            hold_flag_o = HOLD_NONE;
        end else if (state == S_RUN) begin
            if (jump_flag_i || hold_flag_ex_i || hold_flag_clint_i)
                hold_flag_o = HOLD_ID;
            else if (hold_flag_rib_i)
                hold_flag_o = HOLD_PC;
            else
                hold_flag_o = HOLD_NONE;
        end
    end

    assign jump_flag_o = jump_flag_i && !rst && (state != S_HALTED);
    assign jump_addr_o = jump_addr_i;

`ifdef HOLD_TIMEOUT_EN
    logic [7:0] rib_cnt;
    logic [8:0] rib_next;

    assign rib_next = {1'b0, rib_cnt} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rib_cnt       <= 8'd0;
            rib_timeout_o <= 1'b0;
        end else if (hold_flag_o == HOLD_PC) begin
            rib_cnt <= (rib_cnt == 8'hFF) ? rib_cnt : rib_next[7:0];
            if (rib_next >= 9'(RIB_TIMEOUT))
                rib_timeout_o <= 1'b1;
        end else begin
            rib_cnt <= 8'd0;
        end
    end
`else
    logic unused_rib_cfg;
    assign unused_rib_cfg = (RIB_TIMEOUT != 0);
    assign rib_timeout_o  = 1'b0;
`endif

endmodule
